// File: rtl/regfile_wb.sv
// Architectural register file with WB write port, two decode read ports that
// see a same-cycle WB bypass, and a shift-register tracker of in-flight late
// results (loads) that raises stallD on a load-use hazard.
module regfile_wb #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned AW          = 5,
  parameter int unsigned LATE_STAGES = 1
) (
  input  logic            clk,
  input  logic            rst,
  // Writeback bus
  input  logic            regwriteW,
  input  logic [AW-1:0]   rdW,
  input  logic [XLEN-1:0] resultW,
  // Decode read ports
  input  logic [AW-1:0]   a1D,
  input  logic [AW-1:0]   a2D,
  output logic [XLEN-1:0] rd1D,
  output logic [XLEN-1:0] rd2D,
  // Issue / hazard interface
  input  logic            issueD,
  input  logic [AW-1:0]   issue_rdD,
  input  logic            issue_lateD,
  input  logic            flushE,
  output logic            stallD
);

  localparam int unsigned NREG = 2 ** AW;

  logic [XLEN-1:0] regs_q [NREG];

  // Tracker slots: slot 0 is the instruction that entered E last cycle.
  logic [LATE_STAGES-1:0] slotV_q, slotV_d;
  logic [AW-1:0]          slotRd_q [LATE_STAGES];
  logic [AW-1:0]          slotRd_d [LATE_STAGES];

  logic wbWrite;
  logic enterLate;

  assign wbWrite   = regwriteW && (rdW != '0);
  // A stalled or flushed decode never reaches E, and x0 results need no tracking.
  assign enterLate = issueD && issue_lateD && !stallD && !flushE && (issue_rdD != '0);

  // Register array: async clear, WB write with x0 writes dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wbWrite) begin
      regs_q[rdW] <= resultW;
    end
  end

  // Read port 1: x0 is zero, then WB bypass, then array.
  always_comb begin
    rd1D = regs_q[a1D];
    if (a1D == '0) begin
      rd1D = '0;
    end else if (regwriteW && (rdW == a1D)) begin
      rd1D = resultW;
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rd2D = regs_q[a2D];
    if (a2D == '0) begin
      rd2D = '0;
    end else if (regwriteW && (rdW == a2D)) begin
      rd2D = resultW;
    end
  end

  // Tracker next state: new entry at slot 0, everything else shifts down.
  always_comb begin
    slotV_d     = '0;
    slotV_d[0]  = enterLate;
    slotRd_d[0] = issue_rdD;
    for (int k = 1; k < int'(LATE_STAGES); k++) begin
      slotV_d[k]  = slotV_q[k-1];
      slotRd_d[k] = slotRd_q[k-1];
    end
  end

  // Tracker state: cleared asynchronously so stallD drops with reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slotV_q <= '0;
      for (int k = 0; k < int'(LATE_STAGES); k++) begin
        slotRd_q[k] <= '0;
      end
    end else begin
      slotV_q <= slotV_d;
      for (int k = 0; k < int'(LATE_STAGES); k++) begin
        slotRd_q[k] <= slotRd_d[k];
      end
    end
  end

  // Load-use hazard: any valid in-flight late result matching a nonzero source.
  always_comb begin
    stallD = 1'b0;
    for (int k = 0; k < int'(LATE_STAGES); k++) begin
      if (slotV_q[k] &&
          (((a1D != '0) && (slotRd_q[k] == a1D)) ||
           ((a2D != '0) && (slotRd_q[k] == a2D)))) begin
        stallD = 1'b1;
      end
    end
  end

endmodule
